// File: rtl/pwm_pkg.sv
// Shared types and constants for the dead-time PWM stage.
package pwm_pkg;

    typedef enum logic [2:0] {
        OFF,
        LO_ON,
        DT_L2H,
        HI_ON,
        DT_H2L
    } pwm_dt_state_t;

    localparam int DT_MIN = 1;

endpackage

// File: rtl/pwm_deadtime_gen_dt_counter.sv
// Loadable down-counter that times one dead-time interval and flags its last cycle.
module dt_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         expired
);
    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] dt_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dt_cnt <= '0;
        end else if (load) begin
            dt_cnt <= load_val;
        end else if (dec && dt_cnt != '0) begin
            dt_cnt <= dt_cnt - ONE;
        end
    end

    assign expired = (dt_cnt <= ONE);

endmodule

// File: rtl/pwm_deadtime_gen.sv
// Turns a single-ended PWM into complementary high/low gate drives separated by a programmable dead time.
module pwm_deadtime_gen
    import pwm_pkg::*;
#(
    parameter int DT_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic            pwm_in,
    input  logic [DT_W-1:0] dead_time,
    output logic            pwm_hi,
    output logic            pwm_lo,
    output logic            dt_active,
    output logic            abort_pulse
);
    pwm_dt_state_t   state, next_state;
    logic            pwm_q;
    logic            from_off;
    logic            load, abort, expired;
    logic [DT_W-1:0] load_val;

    assign load_val = (dead_time == '0) ? DT_W'(DT_MIN) : dead_time;

    dt_counter #(.W(DT_W)) u_dt_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .dec      (enable && (state == DT_L2H || state == DT_H2L)),
        .expired  (expired)
    );

    always_comb begin
        next_state = state;
        load       = 1'b0;
        abort      = 1'b0;
        if (!enable) begin
            next_state = OFF;
        end else begin
            case (state)
                OFF: begin
                    next_state = pwm_q ? DT_L2H : DT_H2L;
                    load       = 1'b1;
                end
                LO_ON: if (pwm_q) begin
                    next_state = DT_L2H;
                    load       = 1'b1;
                end
                HI_ON: if (!pwm_q) begin
                    next_state = DT_H2L;
                    load       = 1'b1;
                end
                // An interval started from OFF has no side to fall back to, so it always runs out.
                DT_L2H: begin
                    if (!from_off && !pwm_q) begin
                        next_state = LO_ON;
                        abort      = 1'b1;
                    end else if (expired) begin
                        next_state = pwm_q ? HI_ON : LO_ON;
                    end
                end
                DT_H2L: begin
                    if (!from_off && pwm_q) begin
                        next_state = HI_ON;
                        abort      = 1'b1;
                    end else if (expired) begin
                        next_state = pwm_q ? HI_ON : LO_ON;
                    end
                end
                default: next_state = OFF;
            endcase
        end
    end

    // NOTE: outputs are decoded from next_state so they flip on the same edge as the state, with no extra cycle of lag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= OFF;
            pwm_q       <= 1'b0;
            from_off    <= 1'b0;
            pwm_hi      <= 1'b0;
            pwm_lo      <= 1'b0;
            dt_active   <= 1'b0;
            abort_pulse <= 1'b0;
        end else begin
            state       <= next_state;
            pwm_q       <= pwm_in;
            if (load) from_off <= (state == OFF);
            pwm_hi      <= (next_state == HI_ON);
            pwm_lo      <= (next_state == LO_ON);
            dt_active   <= (next_state == DT_L2H) || (next_state == DT_H2L);
            abort_pulse <= abort;
        end
    end

endmodule

// File: doc/pwm_deadtime_gen.md
Name: pwm_deadtime_gen

Overview:
Downstream stage of the PWM generator. Takes the single-ended PWM_OUT and produces complementary high-side/low-side gate drives with programmable dead time. Neither output is ever high at the same time as the other, on any cycle. Sits between the PWM generator and the board-level half-bridge driver pins, on the same clock.

Parameters:
DT_W, 4, width of dead_time port; maximum dead time is 2^DT_W-1 cycles.

Ports:
clk  input  1  system clock, same domain as PWM generator
rst_n  input  1  asynchronous active-low reset
enable  input  1  1 = drive outputs; 0 = force both outputs low
pwm_in  input  1  single-ended PWM from the generator (PWM_OUT)
dead_time  input  DT_W  dead-time length in clk cycles; 0 is treated as 1
pwm_hi  output  1  high-side gate drive, registered
pwm_lo  output  1  low-side gate drive, registered
dt_active  output  1  1 while in a dead-time interval, registered
abort_pulse  output  1  one-cycle pulse when a dead-time interval is aborted

Behaviour:
- Reset (rst_n=0, async): state=OFF; pwm_hi=0, pwm_lo=0, dt_active=0, abort_pulse=0; pwm_q=0; dt_cnt=0.
- pwm_in is registered once into pwm_q. The FSM acts on pwm_q.
- Outputs are registered and decoded from next-state, so they change on the same edge as the state.
- FSM states: OFF, LO_ON, DT_L2H, HI_ON, DT_H2L.
  - OFF: both outputs 0. If enable=1: go to DT_L2H if pwm_q=1, else go to DT_H2L. Load dt_cnt.
  - LO_ON: pwm_lo=1. If pwm_q=1: go to DT_L2H and load dt_cnt.
  - DT_L2H: both outputs 0; dt_cnt decrements each cycle.
    - If pwm_q=0 before expiry: abort, go to LO_ON, pulse abort_pulse. The high side was never on, so re-enabling the low side is safe.
    - When dt_cnt reaches 1 and pwm_q=1: go to HI_ON.
  - HI_ON: pwm_hi=1. If pwm_q=0: go to DT_H2L and load dt_cnt.
  - DT_H2L: mirror of DT_L2H.
    - If pwm_q=1 before expiry: abort, go to HI_ON, pulse abort_pulse.
    - On expiry: go to LO_ON.
- Exception: an interval entered from OFF never aborts. On expiry it goes to HI_ON if pwm_q=1, else LO_ON.
- dt_cnt load value: dead_time, or 1 if dead_time=0. dead_time is sampled only at load; changes mid-interval take effect at the next interval.
- Both-off duration: exactly max(dead_time,1) cycles.
- Latency:
  - pwm_in changes before edge N, so pwm_q updates at N.
  - The active output drops at edge N+1.
  - The opposite output rises at edge N+1+max(dead_time,1).
- dt_active=1 exactly when state is DT_L2H or DT_H2L.
- enable=0 in any state: next edge goes to OFF, both outputs 0. enable takes priority over all transitions.
- Async reset mid-interval: outputs go low immediately, with no clock edge needed.
- Invariant: pwm_hi & pwm_lo == 0 on every cycle.
- Duty 0% or 100% upstream (pwm_in constant): one output is held steady after the initial dead time.

Decomposition:
- Shared package pwm_pkg holds:
  - the state enum typedef pwm_dt_state_t (OFF, LO_ON, DT_L2H, HI_ON, DT_H2L);
  - the constant DT_MIN = 1.
- One natural sub-module: dt_counter, a loadable down-counter with an expired flag. Everything else stays in the top module.

Test Plan:
- Reset, then enable=1, pwm_in=0, dead_time=3 -> pwm_lo rises 3 cycles after leaving OFF; dt_active=1 for exactly 3 cycles; pwm_hi stays 0.
- In LO_ON, dead_time=3, pwm_in rises before edge N -> pwm_lo=0 from N+1; pwm_hi=1 from N+4; both 0 for 3 cycles.
- dead_time=0 with pwm_in toggling every 10 cycles -> both-off gap is exactly 1 cycle on each transition.
- dead_time=5, pwm_in high for only 2 cycles from LO_ON -> abort_pulse=1 for one cycle; pwm_lo returns to 1; pwm_hi never asserts.
- Drive PWM generator output (period 10, duty 2..9) with dead_time=2 for 1000 cycles, checking every cycle -> assertion pwm_hi&pwm_lo==0 never fires; pwm_hi high time = duty-2 cycles per period.
- Drop enable mid-HI_ON, then pulse rst_n low mid-DT_L2H -> both outputs 0 on the next edge after enable drops; async reset clears outputs with no clock edge.
